// File: rtl/array_pkg.sv
// Shared definitions for the systolic-array result drain: word layout
// constants, drain FSM state encoding and the result-word packer.
package array_pkg;

  localparam int NUM_RESULTS   = 16;
  localparam int ACC_W         = 17;
  localparam int IDX_W         = 4;
  localparam int DRAIN_IDX_LSB = 24;
  localparam int DRAIN_TAG_LSB = 28;
  localparam logic [3:0] CSUM_TAG = 4'hC;
  localparam logic [3:0] CSUM_IDX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CSUM  = 2'd2,
    ST_CLEAR = 2'd3
  } drain_state_t;

  // Result in the low bits, index in [27:24], everything else zero.
  function automatic logic [31:0] pack_word(input logic [ACC_W-1:0] result,
                                            input logic [IDX_W-1:0] index);
    logic [31:0] w;
    w = '0;
    w[ACC_W-1:0] = result;
    w[DRAIN_IDX_LSB +: IDX_W] = index;
    return w;
  endfunction

endpackage

// File: rtl/array_result_drain_if.sv
// Result word stream toward the bus-side result FIFO.
// Handshake: a word transfers on every rising clk edge where dout_valid and
// dout_ready are both high; once dout_valid is raised, dout and dout_valid
// stay stable until that transfer happens.
interface array_result_drain_if;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/array_drain_out_reg.sv
// Valid/ready output stage: holds the current result word until it is
// accepted. The FSM either loads a new word (valid set) or drops valid.
module array_drain_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drop_i,
  input  logic [31:0] word_i,
  output logic        xfer_o,
  array_result_drain_if.master m
);

  logic [31:0] dout_q, dout_d;
  logic        valid_q, valid_d;

  assign xfer_o       = valid_q & m.dout_ready;
  assign m.dout       = dout_q;
  assign m.dout_valid = valid_q;

  // Next word/valid: load wins, otherwise drop, otherwise hold stable.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    if (load_i) begin
      dout_d  = word_i;
      valid_d = 1'b1;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/array_result_drain.sv
// Snapshots the 16 systolic-array accumulators on start, streams them as
// 32-bit words, then pulses the accumulator clear and signals done.
// Optional checksum word: define ARRAY_DRAIN_CHECKSUM_EN to append a 17th
// word carrying the XOR of all snapshot results (index 4'hF, tag 4'hC).
module array_result_drain
  import array_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int CLEAR_CYCLES = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic [NUM_RESULTS*(2*DATA_SIZE+1)-1:0] results,
  output logic acc_clear_n,
  output logic busy,
  output logic done,
  output drain_state_t dbg_state,
  array_result_drain_if.master m
);

  localparam int RES_W = 2*DATA_SIZE + 1;
  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  drain_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [RES_W-1:0] snap_q [NUM_RESULTS];
  logic [RES_W-1:0] snap_d [NUM_RESULTS];
  logic             acc_clear_n_q, acc_clear_n_d;
  logic             done_q, done_d;

  logic        load;
  logic        drop;
  logic [31:0] word;
  logic        xfer;

`ifdef ARRAY_DRAIN_CHECKSUM_EN
  logic [RES_W-1:0] csum;
  logic [31:0]      csum_word;

  // XOR of all snapshot results, tagged as the trailing checksum word.
  always_comb begin
    csum = '0;
    for (int k = 0; k < NUM_RESULTS; k++) csum = csum ^ snap_q[k];
    csum_word = pack_word(ACC_W'(csum), CSUM_IDX);
    csum_word[DRAIN_TAG_LSB +: 4] = CSUM_TAG;
  end
`endif

  assign acc_clear_n = acc_clear_n_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

  // Drain sequencing: capture, stream words, hold clear, pulse done.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    clr_cnt_d     = clr_cnt_q;
    snap_d        = snap_q;
    acc_clear_n_d = 1'b1;
    done_d        = 1'b0;
    load          = 1'b0;
    drop          = 1'b0;
    word          = '0;
    case (state_q)
      ST_IDLE: begin
        // done_q marks the cycle right after a drain; start is refused there.
        if (start && !done_q) begin
          for (int k = 0; k < NUM_RESULTS; k++) snap_d[k] = results[k*RES_W +: RES_W];
          idx_d   = '0;
          load    = 1'b1;
          word    = pack_word(ACC_W'(results[RES_W-1:0]), '0);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (idx_q != IDX_W'(NUM_RESULTS-1)) begin
            idx_d = idx_q + 1'b1;
            load  = 1'b1;
            word  = pack_word(ACC_W'(snap_q[idx_q + 1'b1]), idx_q + 1'b1);
          end else begin
`ifdef ARRAY_DRAIN_CHECKSUM_EN
            load    = 1'b1;
            word    = csum_word;
            state_d = ST_CSUM;
`else
            drop          = 1'b1;
            acc_clear_n_d = 1'b0;
            clr_cnt_d     = '0;
            state_d       = ST_CLEAR;
`endif
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          drop          = 1'b1;
          acc_clear_n_d = 1'b0;
          clr_cnt_d     = '0;
          state_d       = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CNT_W'(CLEAR_CYCLES-1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d     = clr_cnt_q + 1'b1;
          acc_clear_n_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counters, snapshot and registered control outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      clr_cnt_q     <= '0;
      acc_clear_n_q <= 1'b1;
      done_q        <= 1'b0;
      for (int k = 0; k < NUM_RESULTS; k++) snap_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      clr_cnt_q     <= clr_cnt_d;
      acc_clear_n_q <= acc_clear_n_d;
      done_q        <= done_d;
      for (int k = 0; k < NUM_RESULTS; k++) snap_q[k] <= snap_d[k];
    end
  end

  array_drain_out_reg u_out (
    .clk    (clk),
    .rst_n  (resetn),
    .load_i (load),
    .drop_i (drop),
    .word_i (word),
    .xfer_o (xfer),
    .m      (m)
  );

endmodule

// File: doc/array_result_drain.md
Name: array_result_drain

Overview:
- Reader-side counterpart to the array/data-delivery link: it collects the 16 accumulator results of the 4x4 systolic array and streams them out.
- On a start pulse it snapshots all results, then emits them as 32-bit words over a valid/ready stream toward the bus-side result FIFO.
- After the final word is accepted, it pulses the array's accumulator clear (accResetn) and signals done.

Parameters:
- DATA_SIZE, 8, operand width; accumulator width ACC_W = 2*DATA_SIZE+1 (17).
- NUM_RESULTS, 16, number of PE results; index field holds 0..15.
- CLEAR_CYCLES, 1, cycles acc_clear_n is held low after a drain (>=1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset.
- start  in  1  request to snapshot and drain results; honoured only in IDLE.
- results  in  NUM_RESULTS*ACC_W  flattened results; PE k (k=0 is c1) at bits [k*ACC_W +: ACC_W].
- dout  out  32  result word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  downstream accepts the word.
- acc_clear_n  out  1  active-low accumulator clear; wired to the array's accResetn.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the drain and the clear are complete.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values (async, resetn low): state=IDLE, dout=0, dout_valid=0, acc_clear_n=1, busy=0, done=0, index counter=0, snapshot=0.
- Reset mid-drain aborts immediately with no done pulse. Partially sent words are lost.
- Word format:
  - dout[16:0] = result, zero-extended for smaller DATA_SIZE.
  - dout[23:17] = 0.
  - dout[27:24] = result index.
  - dout[31:28] = 4'h0.
- State IDLE:
  - start=1 at edge N latches all results into the snapshot register.
  - Sets index=0 and enters SEND.
  - dout_valid rises after edge N (1-cycle latency). dout = word 0 from the same edge.
- State SEND:
  - A transfer occurs on an edge with dout_valid&dout_ready.
  - On transfer with index<NUM_RESULTS-1: index++, and dout loads the next word on the same edge. Zero-bubble: one word per cycle under constant ready.
  - On transfer of the last word: dout_valid=0, enter CLEAR.
  - While valid&!ready: dout and dout_valid hold stable. dout_valid never drops without a transfer.
  - start is ignored in SEND and CLEAR. No queuing.
- State CLEAR:
  - acc_clear_n=0 for exactly CLEAR_CYCLES cycles (registered output).
  - Then acc_clear_n=1, done=1 for one cycle, return to IDLE.
  - A start coinciding with the done cycle is ignored. start is accepted from the next cycle.
- Snapshot isolation: changes to results after the capture edge never alter streamed words, including accumulators still counting.
- Total drain under constant ready: 16 transfer cycles + CLEAR_CYCLES + 1 (done).

Optional Feature:
- Macro: ARRAY_DRAIN_CHECKSUM_EN.
- Defined:
  - After word 15, a 17th word is sent in state CSUM, before CLEAR.
  - dout[16:0] = XOR of the 16 snapshot results; dout[27:24]=4'hF; dout[31:28]=4'hC.
  - The same valid/ready rules apply.
- Undefined: no CSUM state; exactly 16 words per drain; CLEAR follows word 15.

Decomposition:
- Shared package array_pkg:
  - constants NUM_RESULTS=16, ACC_W, DRAIN_IDX_LSB=24, DRAIN_TAG_LSB=28, CSUM_TAG=4'hC;
  - state enum (IDLE, SEND, CSUM, CLEAR);
  - function pack_word(result, index).
- One natural sub-module: array_drain_out_reg. It is the valid/ready output stage holding dout/dout_valid, with load/advance control from the FSM.
- Snapshot register, index counter and clear counter stay in the top.

Test Plan:
- Results k -> 17'h100+k; start pulse; ready=1 constant -> 16 words on consecutive cycles, word k = {4'h0,k[3:0],7'h0,17'h100+k}; acc_clear_n low 1 cycle; done pulse 1 cycle later; busy low after.
- Same stimulus; ready toggles 1,0,0,1,... -> no word lost or duplicated; dout stable while stalled; index sequence 0..15.
- Start, then change all results to 17'h1FFFF one cycle later -> streamed words still carry the snapshot values 17'h100+k.
- Assert resetn low after word 5 accepted -> all outputs at reset values asynchronously, no done; a later start streams from index 0.
- Start pulses held during SEND and in the done cycle -> ignored; exactly one drain; the next start after IDLE is accepted.
- With ARRAY_DRAIN_CHECKSUM_EN, results k -> k+1 -> 17th word dout = 32'hCF000010 (XOR of 1..16 = 16); then CLEAR; without the macro, exactly 16 words.
